tl_dbg_mon: RTL and testbench



---
 rtl/tl_dbg_mon.sv | 318 +++++++++++++++++++++++++++++++
 tb/tb_tl_dbg_mon.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_dbg_mon.sv
// Passive TL-UL monitor: outstanding-request table, per-transaction latency and a trace FIFO.
// Optional protocol checker enabled by defining TL_DBG_MON_PROTO_CHECK_EN.

package tlul_pkg;
    parameter int unsigned TL_AW  = 32;
    parameter int unsigned TL_DW  = 32;
    parameter int unsigned TL_AIW = 8;
    parameter int unsigned TL_DIW = 1;
    parameter int unsigned TL_SZW = 2;
    parameter int unsigned TL_DBW = TL_DW / 8;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic                a_valid;
        tl_a_op_e            a_opcode;
        logic [2:0]          a_param;
        logic [TL_SZW-1:0]   a_size;
        logic [TL_AIW-1:0]   a_source;
        logic [TL_AW-1:0]    a_address;
        logic [TL_DBW-1:0]   a_mask;
        logic [TL_DW-1:0]    a_data;
        logic                d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic                d_valid;
        tl_d_op_e            d_opcode;
        logic [2:0]          d_param;
        logic [TL_SZW-1:0]   d_size;
        logic [TL_AIW-1:0]   d_source;
        logic [TL_DIW-1:0]   d_sink;
        logic [TL_DW-1:0]    d_data;
        logic                d_error;
        logic                a_ready;
    } tl_d2h_t;
endpackage

module tl_dbg_mon #(
    parameter int unsigned NumOutstanding = 4,
    parameter int unsigned TraceDepth     = 8,
    parameter int unsigned LatW           = 8,
    parameter int unsigned CntW           = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  tlul_pkg::tl_h2d_t             tl_h2d_i,
    input  tlul_pkg::tl_d2h_t             tl_d2h_i,
    input  logic                          enable_i,
    input  logic                          clear_i,
    output logic                          trace_valid_o,
    input  logic                          trace_ready_i,
    output logic [tlul_pkg::TL_AW-1:0]    trace_addr_o,
    output logic [tlul_pkg::TL_AIW-1:0]   trace_source_o,
    output logic                          trace_write_o,
    output logic                          trace_error_o,
    output logic [LatW-1:0]               trace_lat_o,
    output logic [CntW-1:0]               req_cnt_o,
    output logic [CntW-1:0]               rsp_cnt_o,
    output logic [CntW-1:0]               drop_cnt_o,
    output logic                          overflow_o,
    output logic                          unmatched_o,
    output logic                          proto_err_o
);
    localparam int unsigned AW   = tlul_pkg::TL_AW;
    localparam int unsigned AIW  = tlul_pkg::TL_AIW;
    localparam int unsigned IdxW = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;
    localparam int unsigned PtrW = $clog2(TraceDepth);
    localparam logic [LatW-1:0] LatMax   = '1;
    localparam logic [PtrW:0]   FifoFull = (PtrW + 1)'(TraceDepth);

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [AIW-1:0]  source;
        logic            write;
        logic            error;
        logic [LatW-1:0] lat;
    } trace_t;

    function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v, input logic inc);
        return (inc && v != '1) ? v + CntW'(1) : v;
    endfunction

    logic a_hs, d_hs, a_write;
    assign a_hs    = tl_h2d_i.a_valid & tl_d2h_i.a_ready;
    assign d_hs    = tl_d2h_i.d_valid & tl_h2d_i.d_ready;
    assign a_write = (tl_h2d_i.a_opcode == tlul_pkg::PutFullData) |
                     (tl_h2d_i.a_opcode == tlul_pkg::PutPartialData);

    logic [NumOutstanding-1:0] tbl_valid_q;
    logic [AIW-1:0]            tbl_src_q   [NumOutstanding];
    logic [AW-1:0]             tbl_addr_q  [NumOutstanding];
    logic                      tbl_write_q [NumOutstanding];
    logic [LatW-1:0]           tbl_age_q   [NumOutstanding];

    // Lowest-index search over start-of-cycle state, so a slot freed now is not reused now.
    logic            match, free_avail;
    logic [IdxW-1:0] match_idx, free_idx;
    always_comb begin
        match      = 1'b0;
        match_idx  = '0;
        free_avail = 1'b0;
        free_idx   = '0;
        for (int i = NumOutstanding - 1; i >= 0; i--) begin
            if (tbl_valid_q[i] && tbl_src_q[i] == tl_d2h_i.d_source) begin
                match     = 1'b1;
                match_idx = IdxW'(i);
            end
            if (!tbl_valid_q[i]) begin
                free_avail = 1'b1;
                free_idx   = IdxW'(i);
            end
        end
    end

    logic zero_lat, alloc, ovf_set, rsp_hit, unm_set, push, req_inc, rsp_inc;
    assign zero_lat = a_hs & d_hs & enable_i & ~match &
                      (tl_h2d_i.a_source == tl_d2h_i.d_source);
    assign alloc    = a_hs & enable_i & ~zero_lat & free_avail;
    assign ovf_set  = a_hs & enable_i & ~zero_lat & ~free_avail;
    assign rsp_hit  = d_hs & match;
    assign unm_set  = d_hs & ~match & ~zero_lat;
    assign push     = enable_i & (rsp_hit | zero_lat);
    assign req_inc  = alloc | zero_lat;
    assign rsp_inc  = rsp_hit | zero_lat;

    trace_t push_data;
    always_comb begin
        if (zero_lat) begin
            push_data = '{addr: tl_h2d_i.a_address, source: tl_h2d_i.a_source, write: a_write,
                          error: tl_d2h_i.d_error, lat: '0};
        end else begin
            push_data = '{addr: tbl_addr_q[match_idx], source: tbl_src_q[match_idx],
                          write: tbl_write_q[match_idx], error: tl_d2h_i.d_error,
                          lat: tbl_age_q[match_idx]};
        end
    end

    // Age is stored one ahead: the register seen in cycle N+k already reads k.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tbl_valid_q <= '0;
            for (int i = 0; i < NumOutstanding; i++) begin
                tbl_src_q[i]   <= '0;
                tbl_addr_q[i]  <= '0;
                tbl_write_q[i] <= 1'b0;
                tbl_age_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NumOutstanding; i++) begin
                if (tbl_valid_q[i] && tbl_age_q[i] != LatMax) begin
                    tbl_age_q[i] <= tbl_age_q[i] + LatW'(1);
                end
            end
            if (rsp_hit) begin
                tbl_valid_q[match_idx] <= 1'b0;
            end
            if (alloc) begin
                tbl_valid_q[free_idx] <= 1'b1;
                tbl_src_q[free_idx]   <= tl_h2d_i.a_source;
                tbl_addr_q[free_idx]  <= tl_h2d_i.a_address;
                tbl_write_q[free_idx] <= a_write;
                tbl_age_q[free_idx]   <= LatW'(1);
            end
        end
    end

    trace_t          mem_q [TraceDepth];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   cnt_q;
    logic            fifo_full, pop, push_ok, drop;
    assign fifo_full = (cnt_q == FifoFull);
    assign pop       = trace_ready_i & (cnt_q != '0);
    assign push_ok   = push & (~fifo_full | pop);
    assign drop      = push & fifo_full & ~pop;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < TraceDepth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            cnt_q <= cnt_q + (PtrW + 1)'(push_ok) - (PtrW + 1)'(pop);
        end
    end

    // Head fields read as zero whenever the FIFO is empty.
    trace_t head;
    assign head           = mem_q[rd_ptr_q];
    assign trace_valid_o  = (cnt_q != '0);
    assign trace_addr_o   = trace_valid_o ? head.addr   : '0;
    assign trace_source_o = trace_valid_o ? head.source : '0;
    assign trace_write_o  = trace_valid_o & head.write;
    assign trace_error_o  = trace_valid_o & head.error;
    assign trace_lat_o    = trace_valid_o ? head.lat    : '0;

    logic [CntW-1:0] req_cnt_q, rsp_cnt_q, drop_cnt_q;
    logic            overflow_q, unmatched_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_cnt_q   <= '0;
            rsp_cnt_q   <= '0;
            drop_cnt_q  <= '0;
            overflow_q  <= 1'b0;
            unmatched_q <= 1'b0;
        end else if (clear_i) begin
            req_cnt_q   <= '0;
            rsp_cnt_q   <= '0;
            drop_cnt_q  <= '0;
            overflow_q  <= 1'b0;
            unmatched_q <= 1'b0;
        end else begin
            req_cnt_q   <= sat_inc(req_cnt_q, req_inc);
            rsp_cnt_q   <= sat_inc(rsp_cnt_q, rsp_inc);
            drop_cnt_q  <= sat_inc(drop_cnt_q, drop);
            overflow_q  <= overflow_q | ovf_set;
            unmatched_q <= unmatched_q | unm_set;
        end
    end

    assign req_cnt_o   = req_cnt_q;
    assign rsp_cnt_o   = rsp_cnt_q;
    assign drop_cnt_o  = drop_cnt_q;
    assign overflow_o  = overflow_q;
    assign unmatched_o = unmatched_q;

`ifdef TL_DBG_MON_PROTO_CHECK_EN
    typedef struct packed {
        tlul_pkg::tl_a_op_e              opcode;
        logic [tlul_pkg::TL_SZW-1:0]     size;
        logic [AIW-1:0]                  source;
        logic [AW-1:0]                   addr;
        logic [tlul_pkg::TL_DBW-1:0]     mask;
        logic [tlul_pkg::TL_DW-1:0]      data;
    } a_pl_t;

    typedef struct packed {
        tlul_pkg::tl_d_op_e              opcode;
        logic [2:0]                      param;
        logic [tlul_pkg::TL_SZW-1:0]     size;
        logic [AIW-1:0]                  source;
        logic [tlul_pkg::TL_DIW-1:0]     sink;
        logic [tlul_pkg::TL_DW-1:0]      data;
        logic                            error;
    } d_pl_t;

    a_pl_t a_pl, a_pl_q;
    d_pl_t d_pl, d_pl_q;
    logic  a_valid_q, a_ready_q, d_valid_q, d_ready_q, proto_q, a_viol, d_viol;

    assign a_pl = '{opcode: tl_h2d_i.a_opcode, size: tl_h2d_i.a_size,
                    source: tl_h2d_i.a_source, addr: tl_h2d_i.a_address,
                    mask: tl_h2d_i.a_mask, data: tl_h2d_i.a_data};
    assign d_pl = '{opcode: tl_d2h_i.d_opcode, param: tl_d2h_i.d_param,
                    size: tl_d2h_i.d_size, source: tl_d2h_i.d_source,
                    sink: tl_d2h_i.d_sink, data: tl_d2h_i.d_data, error: tl_d2h_i.d_error};

    // A stalled beat from last cycle must still be presented, unchanged.
    assign a_viol = a_valid_q & ~a_ready_q & (~tl_h2d_i.a_valid | (a_pl != a_pl_q));
    assign d_viol = d_valid_q & ~d_ready_q & (~tl_d2h_i.d_valid | (d_pl != d_pl_q));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_valid_q <= 1'b0;
            a_ready_q <= 1'b0;
            d_valid_q <= 1'b0;
            d_ready_q <= 1'b0;
            a_pl_q    <= '0;
            d_pl_q    <= '0;
            proto_q   <= 1'b0;
        end else begin
            a_valid_q <= tl_h2d_i.a_valid;
            a_ready_q <= tl_d2h_i.a_ready;
            d_valid_q <= tl_d2h_i.d_valid;
            d_ready_q <= tl_h2d_i.d_ready;
            a_pl_q    <= a_pl;
            d_pl_q    <= d_pl;
            proto_q   <= clear_i ? 1'b0 : (proto_q | a_viol | d_viol);
        end
    end

    assign proto_err_o = proto_q;

    logic unused_fields;
    assign unused_fields = ^tl_h2d_i.a_param;
`else
    assign proto_err_o = 1'b0;

    logic unused_fields;
    assign unused_fields = ^{tl_h2d_i.a_param, tl_h2d_i.a_size, tl_h2d_i.a_mask,
                             tl_h2d_i.a_data, tl_d2h_i.d_opcode, tl_d2h_i.d_param,
                             tl_d2h_i.d_size, tl_d2h_i.d_sink, tl_d2h_i.d_data};
`endif

endmodule

// File: tb/tb_tl_dbg_mon.sv
// Bench for tl_dbg_mon: directed scenarios with literal expectations plus randomized traffic,
// all checked every cycle against a transaction-level model of the monitor.

module tb_tl_dbg_mon;
    localparam int unsigned NumOut = 4;
    localparam int unsigned Depth  = 8;
    localparam int unsigned LatW   = 8;
    localparam int unsigned CntW   = 16;
    localparam int unsigned AW     = tlul_pkg::TL_AW;
    localparam int unsigned IW     = tlul_pkg::TL_AIW;
    localparam longint LatMax = (64'd1 << LatW) - 1;
    localparam longint CntMax = (64'd1 << CntW) - 1;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    tlul_pkg::tl_h2d_t h2d;
    tlul_pkg::tl_d2h_t d2h;
    logic enable, clear, tr_ready;
    logic            trace_valid, trace_write, trace_error;
    logic [AW-1:0]   trace_addr;
    logic [IW-1:0]   trace_source;
    logic [LatW-1:0] trace_lat;
    logic [CntW-1:0] req_cnt, rsp_cnt, drop_cnt;
    logic            overflow, unmatched, proto_err;

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;

    always #5 clk_i = ~clk_i;

    tl_dbg_mon #(
        .NumOutstanding(NumOut),
        .TraceDepth    (Depth),
        .LatW          (LatW),
        .CntW          (CntW)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .tl_h2d_i      (h2d),
        .tl_d2h_i      (d2h),
        .enable_i      (enable),
        .clear_i       (clear),
        .trace_valid_o (trace_valid),
        .trace_ready_i (tr_ready),
        .trace_addr_o  (trace_addr),
        .trace_source_o(trace_source),
        .trace_write_o (trace_write),
        .trace_error_o (trace_error),
        .trace_lat_o   (trace_lat),
        .req_cnt_o     (req_cnt),
        .rsp_cnt_o     (rsp_cnt),
        .drop_cnt_o    (drop_cnt),
        .overflow_o    (overflow),
        .unmatched_o   (unmatched),
        .proto_err_o   (proto_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [IW-1:0]   src;
        logic            wr;
        logic            err;
        logic [LatW-1:0] lat;
    } tr_t;

    bit            m_v    [NumOut];
    logic [IW-1:0] m_src  [NumOut];
    logic [AW-1:0] m_addr [NumOut];
    bit            m_wr   [NumOut];
    longint        m_t    [NumOut];
    tr_t           mq[$];
    longint        cyc, m_req, m_rsp, m_drop;
    bit            m_ovf, m_unm, m_perr;
    tlul_pkg::tl_h2d_t ph;
    tlul_pkg::tl_d2h_t pd;

    function automatic bit is_put(input tlul_pkg::tl_a_op_e op);
        return op == tlul_pkg::PutFullData || op == tlul_pkg::PutPartialData;
    endfunction

    function automatic longint sat(input longint v, input longint mx);
        return (v > mx) ? mx : v;
    endfunction

    always @(posedge clk_i) begin : model_step
        int  mi, fi;
        bit  ahs, dhs, zl, push, pop, ovf_s, unm_s, perr_s;
        tr_t e;
        if (!rst_ni) begin
            for (int i = 0; i < NumOut; i++) m_v[i] = 1'b0;
            mq.delete();
            cyc = 0; m_req = 0; m_rsp = 0; m_drop = 0;
            m_ovf = 0; m_unm = 0; m_perr = 0;
            ph = '0; pd = '0;
        end else begin
            cyc++;
            ahs = h2d.a_valid && d2h.a_ready;
            dhs = d2h.d_valid && h2d.d_ready;
            mi = -1; fi = -1;
            for (int i = 0; i < NumOut; i++) begin
                if (mi < 0 && m_v[i] && m_src[i] == d2h.d_source) mi = i;
                if (fi < 0 && !m_v[i]) fi = i;
            end
            zl = ahs && dhs && enable && h2d.a_source == d2h.d_source && mi < 0;
            push = 0; ovf_s = 0; unm_s = 0; perr_s = 0; e = '0;
            if (dhs && mi >= 0) begin
                e = '{addr: m_addr[mi], src: m_src[mi], wr: m_wr[mi], err: d2h.d_error,
                      lat: LatW'(sat(cyc - m_t[mi], LatMax))};
                push = enable;
                m_v[mi] = 1'b0;
                if (!clear) m_rsp++;
            end else if (zl) begin
                e = '{addr: h2d.a_address, src: h2d.a_source, wr: is_put(h2d.a_opcode),
                      err: d2h.d_error, lat: '0};
                push = 1;
                if (!clear) begin m_rsp++; m_req++; end
            end else if (dhs) begin
                unm_s = 1;
            end
            if (ahs && enable && !zl) begin
                if (fi >= 0) begin
                    m_v[fi] = 1'b1; m_src[fi] = h2d.a_source; m_addr[fi] = h2d.a_address;
                    m_wr[fi] = is_put(h2d.a_opcode); m_t[fi] = cyc;
                    if (!clear) m_req++;
                end else begin
                    ovf_s = 1;
                end
            end
`ifdef TL_DBG_MON_PROTO_CHECK_EN
            perr_s = (ph.a_valid && !pd.a_ready && (!h2d.a_valid ||
                      {h2d.a_opcode, h2d.a_size, h2d.a_source, h2d.a_address, h2d.a_mask,
                       h2d.a_data} != {ph.a_opcode, ph.a_size, ph.a_source, ph.a_address,
                       ph.a_mask, ph.a_data})) ||
                     (pd.d_valid && !ph.d_ready && (!d2h.d_valid ||
                      {d2h.d_opcode, d2h.d_param, d2h.d_size, d2h.d_source, d2h.d_sink,
                       d2h.d_data, d2h.d_error} != {pd.d_opcode, pd.d_param, pd.d_size,
                       pd.d_source, pd.d_sink, pd.d_data, pd.d_error}));
`endif
            ph = h2d; pd = d2h;
            pop = tr_ready && mq.size() > 0;
            if (clear) begin
                mq.delete();
                m_req = 0; m_rsp = 0; m_drop = 0;
                m_ovf = 0; m_unm = 0; m_perr = 0;
            end else begin
                if (pop) void'(mq.pop_front());
                if (push) begin
                    if (mq.size() < Depth) mq.push_back(e);
                    else m_drop++;
                end
                m_ovf  = m_ovf | ovf_s;
                m_unm  = m_unm | unm_s;
                m_perr = m_perr | perr_s;
            end
        end
    end

    tr_t hd;
    always @(negedge clk_i) begin
        if (chk_on && rst_ni) begin
            hd = (mq.size() > 0) ? mq[0] : '0;
            chk("m_valid", trace_valid, mq.size() > 0);
            chk("m_addr", trace_addr, hd.addr);
            chk("m_source", trace_source, hd.src);
            chk("m_write", trace_write, hd.wr);
            chk("m_error", trace_error, hd.err);
            chk("m_lat", trace_lat, hd.lat);
            chk("m_req_cnt", req_cnt, sat(m_req, CntMax));
            chk("m_rsp_cnt", rsp_cnt, sat(m_rsp, CntMax));
            chk("m_drop_cnt", drop_cnt, sat(m_drop, CntMax));
            chk("m_overflow", overflow, m_ovf);
            chk("m_unmatched", unmatched, m_unm);
            chk("m_proto_err", proto_err, m_perr);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk_i);
        #1;
    endtask

    task automatic idle();
        h2d = '0; d2h = '0;
        h2d.a_opcode = tlul_pkg::Get;
        d2h.a_ready = 1'b1;
        h2d.d_ready = 1'b1;
    endtask

    task automatic do_reset();
        idle();
        enable = 1'b1; clear = 1'b0; tr_ready = 1'b0;
        rst_ni = 1'b0;
        step(); step();
        rst_ni = 1'b1;
    endtask

    task automatic a_beat(input logic [IW-1:0] src, input logic [AW-1:0] addr);
        h2d.a_valid = 1'b1; h2d.a_opcode = tlul_pkg::Get;
        h2d.a_source = src; h2d.a_address = addr;
    endtask

    task automatic d_beat(input logic [IW-1:0] src);
        d2h.d_valid = 1'b1; d2h.d_opcode = tlul_pkg::AccessAckData; d2h.d_source = src;
    endtask

    task automatic randomize_bus();
        h2d.a_valid   = ($urandom_range(0, 1) == 1);
        h2d.a_opcode  = ($urandom_range(0, 2) == 0) ? tlul_pkg::PutFullData :
                        ($urandom_range(0, 1) == 0) ? tlul_pkg::PutPartialData : tlul_pkg::Get;
        h2d.a_source  = IW'($urandom_range(0, 5));
        h2d.a_address = $urandom;
        h2d.a_mask    = 4'($urandom);
        h2d.a_data    = $urandom;
        h2d.d_ready   = ($urandom_range(0, 9) < 7);
        d2h.a_ready   = ($urandom_range(0, 9) < 6);
        d2h.d_valid   = ($urandom_range(0, 1) == 1);
        d2h.d_source  = IW'($urandom_range(0, 5));
        d2h.d_error   = ($urandom_range(0, 7) == 0);
        d2h.d_data    = $urandom;
        enable        = ($urandom_range(0, 9) != 0);
        clear         = ($urandom_range(0, 49) == 0);
        tr_ready      = ($urandom_range(0, 1) == 1);
    endtask

    initial begin
        idle();
        enable = 1'b1; clear = 1'b0; tr_ready = 1'b0;
        do_reset();
        chk_on = 1'b1;

        // Reset values
        chk("rst_valid", trace_valid, 0);
        chk("rst_req", req_cnt, 0);
        chk("rst_flags", {overflow, unmatched, proto_err}, 0);

        // Get src 3 @0x1000, response 5 cycles later
        a_beat(3, 32'h1000); step(); idle();
        repeat (4) step();
        d_beat(3); step(); idle();
        chk("t1_valid", trace_valid, 1);
        chk("t1_addr", trace_addr, 32'h1000);
        chk("t1_src", trace_source, 3);
        chk("t1_write", trace_write, 0);
        chk("t1_lat", trace_lat, 5);
        chk("t1_req", req_cnt, 1);
        chk("t1_rsp", rsp_cnt, 1);

        // Table overflow and unmatched response
        do_reset();
        for (int s = 0; s < 5; s++) begin a_beat(IW'(s), 32'h40 * s); step(); end
        idle();
        chk("t2_overflow", overflow, 1);
        chk("t2_req", req_cnt, 4);
        chk("t2_unm_before", unmatched, 0);
        d_beat(4); step(); idle();
        chk("t2_unmatched", unmatched, 1);
        chk("t2_rsp", rsp_cnt, 0);
        // Reset discards in-flight entries
        a_beat(1, 32'h80); step(); idle();
        do_reset();
        d_beat(1); step(); idle();
        chk("t2_rst_unm", unmatched, 1);

        // Zero-latency same-cycle A and D
        do_reset();
        a_beat(7, 32'h700); d_beat(7); step(); idle();
        chk("t3_valid", trace_valid, 1);
        chk("t3_src", trace_source, 7);
        chk("t3_lat", trace_lat, 0);
        chk("t3_cnts", {req_cnt, rsp_cnt}, {16'd1, 16'd1});
        chk("t3_flags", {overflow, unmatched}, 0);

        // FIFO fill, drop, pop+push while full, drain order
        do_reset();
        for (int k = 0; k < 10; k++) begin
            a_beat(IW'(k), 32'h100 * (k + 1)); step(); idle();
            d_beat(IW'(k)); step(); idle();
        end
        chk("t4_drop", drop_cnt, 2);
        a_beat(5, 32'hABC0); step(); idle();
        d_beat(5); tr_ready = 1'b1; step(); idle(); tr_ready = 1'b0;
        chk("t4_drop_pp", drop_cnt, 2);
        for (int j = 0; j < 8; j++) begin
            chk("t4_order", trace_addr, (j < 7) ? 32'h100 * (j + 2) : 32'hABC0);
            tr_ready = 1'b1; step(); tr_ready = 1'b0;
        end
        chk("t4_empty", trace_valid, 0);

        // Latency saturation, clear, table survives clear
        do_reset();
        a_beat(2, 32'h2000); step(); idle();
        repeat (299) step();
        d_beat(2); step(); idle();
        chk("t5_lat_sat", trace_lat, 255);
        a_beat(6, 32'h6000); step(); idle();
        d_beat(1); step(); idle();
        chk("t5_unm", unmatched, 1);
        clear = 1'b1; step(); clear = 1'b0;
        chk("t5_clr_cnts", {req_cnt, rsp_cnt, drop_cnt}, 0);
        chk("t5_clr_flags", {overflow, unmatched, proto_err}, 0);
        chk("t5_clr_fifo", trace_valid, 0);
        d_beat(6); step(); idle();
        chk("t5_match_src", trace_source, 6);
        chk("t5_match_rsp", rsp_cnt, 1);

        // Address change while A is stalled
        do_reset();
        a_beat(1, 32'h10); d2h.a_ready = 1'b0; step();
        h2d.a_address = 32'h14; step(); idle();
`ifdef TL_DBG_MON_PROTO_CHECK_EN
        chk("t6_proto", proto_err, 1);
`else
        chk("t6_proto", proto_err, 0);
`endif

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            randomize_bus();
            if ($urandom_range(0, 999) == 0) do_reset();
            else step();
        end
        idle(); clear = 1'b0; step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
